niosii_microprocessor_data_out_pio: RTL and testbench

Avalon-MM slave output PIO that drives a parallel output bus from the Nios II processor. It is the write-direction counterpart of the input PIOs on the same system interconnect, and in the SRAM lab it drives address and control lines outward. The block has one data register with write, bit-set and bit-clear access, registered readback, a one-cycle change strobe and a free-running change counter.

---
 rtl/niosii_microprocessor_data_out_pio.sv | 93 +++++++++
 tb/tb_niosii_microprocessor_data_out_pio.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/niosii_microprocessor_data_out_pio.sv
//------------------------------------------------------------------------------
// Module : niosii_microprocessor_data_out_pio
// Brief  : Avalon-MM output PIO with write/set/clear access, registered
//          readback, a one-cycle change strobe and a 16-bit change counter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module niosii_microprocessor_data_out_pio #(
  parameter int unsigned      WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_strobe
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_SET   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR = 2'd3;

  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      count_q, count_d;
  logic             strobe_q, strobe_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] wr_bits;
  logic             wr_en;
  logic             changed;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  // Bits of writedata above WIDTH are architecturally ignored.
  if (WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:  data_d = wr_bits;
        ADDR_SET:   data_d = data_q | wr_bits;
        ADDR_CLEAR: data_d = data_q & ~wr_bits;
        default:    data_d = data_q;
      endcase
    end
  end

  // Only a real value change counts; redundant writes are silent.
  assign changed  = (data_d != data_q);
  assign strobe_d = changed;
  assign count_d  = changed ? count_q + 16'd1 : count_q;

  // Readback samples pre-edge state, so a same-cycle write returns old data.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:  readdata_d[WIDTH-1:0] = data_q;
      ADDR_COUNT: readdata_d[15:0]      = count_q;
      default:    readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      count_q    <= '0;
      strobe_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      count_q    <= count_d;
      strobe_q   <= strobe_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port   = data_q;
  assign out_strobe = strobe_q;
  assign readdata   = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_niosii_microprocessor_data_out_pio.sv
//------------------------------------------------------------------------------
// Module : tb_niosii_microprocessor_data_out_pio
// Brief  : Directed bench with a cycle-level reference model of the output PIO.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_niosii_microprocessor_data_out_pio;

  localparam int W = 10;
  localparam logic [W-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          out_strobe;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Reference state, updated once per rising edge from the register-map rules.
  int unsigned m_data, m_count, m_read;
  bit          m_strobe;

  always #5 clk = ~clk;

  niosii_microprocessor_data_out_pio #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_strobe (out_strobe)
  );

  always @(posedge clk) begin
    int unsigned mask, wd, nxt;
    mask = (1 << W) - 1;
    wd   = writedata & mask;
    if (reset) begin
      m_data = RV; m_count = 0; m_strobe = 1'b0; m_read = 0;
    end else begin
      nxt = m_data;
      if (chipselect && !write_n) begin
        if (address == 2'd0) nxt = wd;
        else if (address == 2'd2) nxt = m_data | wd;
        else if (address == 2'd3) nxt = m_data & ~wd & mask;
      end
      m_read   = (address == 2'd0) ? m_data : (address == 2'd1) ? m_count : 0;
      m_strobe = (nxt != m_data);
      if (m_strobe) m_count = (m_count + 1) % 65536;
      m_data = nxt;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model out_port", longint'(out_port), longint'(m_data));
      chk("model out_strobe", longint'(out_strobe), longint'(m_strobe));
      chk("model readdata", longint'(readdata), longint'(m_read));
    end
  end

  // Apply one cycle of bus inputs; returns at the following falling edge.
  task automatic drive(input bit rst, input logic [1:0] a, input bit cs,
                       input bit wn, input logic [31:0] wd);
    reset = rst; address = a; chipselect = cs; write_n = wn; writedata = wd;
    @(negedge clk);
  endtask

  initial begin
    int lows;
    drive(1, 2'd0, 1, 0, 32'h0000_03FF);
    drive(1, 2'd0, 1, 0, 32'h0000_03FF);
    checking = 1'b1;
    chk("reset out_port", out_port, 0);
    chk("reset readdata", readdata, 0);
    chk("reset strobe", out_strobe, 0);
    drive(0, 2'd1, 0, 1, 32'h0);
    chk("reset count", readdata, 0);

    drive(0, 2'd0, 1, 0, 32'hFFFF_F2A5);
    chk("write out_port", out_port, 10'h2A5);
    chk("write strobe", out_strobe, 1);
    drive(0, 2'd0, 1, 1, 32'h0);
    chk("read data", readdata, 32'h0000_02A5);
    chk("strobe one cycle", out_strobe, 0);

    drive(0, 2'd2, 1, 0, 32'h0000_000F);
    chk("set out_port", out_port, 10'h2AF);
    drive(0, 2'd3, 1, 0, 32'h0000_02A0);
    chk("clear out_port", out_port, 10'h00F);
    drive(0, 2'd2, 1, 0, 32'h0000_000F);
    chk("redundant set strobe", out_strobe, 0);
    drive(0, 2'd1, 1, 1, 32'h0);
    chk("count after set/clear", readdata, 3);

    drive(0, 2'd0, 1, 0, 32'h0000_00AA);
    drive(0, 2'd0, 1, 0, 32'h0000_0155);
    chk("same-cycle read old", readdata, 32'h0AA);
    chk("same-cycle out_port", out_port, 10'h155);
    drive(0, 2'd0, 1, 1, 32'h0);
    chk("read new", readdata, 32'h155);

    drive(1, 2'd2, 1, 0, 32'h0000_0300);
    chk("mid reset out_port", out_port, RV);
    chk("mid reset strobe", out_strobe, 0);
    drive(0, 2'd0, 0, 0, 32'h0000_03FF);
    chk("cs=0 out_port", out_port, RV);
    drive(0, 2'd0, 1, 1, 32'h0000_03FF);
    chk("write_n=1 out_port", out_port, RV);
    drive(0, 2'd1, 1, 0, 32'h0000_FFFF);
    chk("count write strobe", out_strobe, 0);
    drive(0, 2'd1, 1, 1, 32'h0);
    chk("count write ignored", readdata, 0);

    lows = 0;
    for (int i = 0; i < 65537; i++) begin
      drive(0, 2'd0, 1, 0, (i % 2 == 0) ? 32'h1 : 32'h2);
      if (out_strobe !== 1'b1) lows++;
    end
    chk("wrap strobe low cycles", lows, 0);
    drive(0, 2'd1, 1, 1, 32'h0);
    chk("wrap count", readdata, 1);

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
